// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// mdu : iterative 32-bit multiply/divide unit with HI/LO registers
// Revision 1.0
// ============================================================================
module mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdCtrl,
  input  logic [31:0] SrcA,
  input  logic [31:0] RD2,
  input  logic        mfSel,
  output logic        busy,
  output logic        done,
  output logic        divZero,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDResult
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [4:0] C_LAST_ITER = 5'd31;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic        is_div_q;
  logic        neg_lo_q;
  logic        neg_hi_q;
  logic [31:0] b_q;
  logic [63:0] p_q;
  logic [63:0] p_d;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] hi_d;
  logic [31:0] lo_d;
  logic        busy_q;
  logic        done_q;
  logic        divzero_q;

  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_req_md;
  logic        w_req_mt;
  logic        w_div0;

  assign w_signed = ~mdCtrl[0];
  assign w_a_neg  = w_signed & SrcA[31];
  assign w_b_neg  = w_signed & RD2[31];
  assign w_a_mag  = w_a_neg ? (~SrcA + 32'd1) : SrcA;
  assign w_b_mag  = w_b_neg ? (~RD2 + 32'd1) : RD2;
  assign w_req_md = start & ~mdCtrl[2];
  assign w_req_mt = start & (mdCtrl[2:1] == 2'b10);
  assign w_div0   = mdCtrl[1] & (RD2 == 32'd0);

  // One iteration: p_q holds {acc, multiplier} or {remainder, dividend/quotient}.
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_sh;
  logic        w_div_ge;
  logic [31:0] w_div_rem;

  always_comb begin
    w_mul_sum = {1'b0, p_q[63:32]} + {1'b0, b_q};
    w_div_sh  = p_q[63:31];
    w_div_ge  = (w_div_sh >= {1'b0, b_q});
    w_div_rem = w_div_ge ? (w_div_sh[31:0] - b_q) : w_div_sh[31:0];
    p_d       = p_q;
    if (is_div_q) begin
      p_d = {w_div_rem, p_q[30:0], w_div_ge};
    end else if (p_q[0]) begin
      p_d = {w_mul_sum, p_q[31:1]};
    end else begin
      p_d = {1'b0, p_q[63:32], p_q[31:1]};
    end
  end

  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  always_comb begin
    w_prod_fix = neg_lo_q ? (~p_q + 64'd1) : p_q;
    w_quo_fix  = neg_lo_q ? (~p_q[31:0] + 32'd1) : p_q[31:0];
    w_rem_fix  = neg_hi_q ? (~p_q[63:32] + 32'd1) : p_q[63:32];
    if (is_div_q) begin
      hi_d = w_rem_fix;
      lo_d = w_quo_fix;
    end else begin
      hi_d = w_prod_fix[63:32];
      lo_d = w_prod_fix[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      b_q       <= 32'd0;
      p_q       <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      case (state_q)
        CALC: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == C_LAST_ITER) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          if (w_req_md) begin
            if (w_div0) begin
              // Divide by zero skips the datapath and leaves HI/LO untouched.
              state_q   <= DONE;
              done_q    <= 1'b1;
              divzero_q <= 1'b1;
            end else begin
              state_q  <= CALC;
              busy_q   <= 1'b1;
              cnt_q    <= 5'd0;
              is_div_q <= mdCtrl[1];
              neg_lo_q <= w_a_neg ^ w_b_neg;
              neg_hi_q <= w_a_neg;
              if (mdCtrl[1]) begin
                b_q <= w_b_mag;
                p_q <= {32'd0, w_a_mag};
              end else begin
                b_q <= w_a_mag;
                p_q <= {32'd0, w_b_mag};
              end
            end
          end else if (w_req_mt) begin
            if (mdCtrl[0]) begin
              lo_q <= SrcA;
            end else begin
              hi_q <= SrcA;
            end
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign divZero  = divzero_q;
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign MDResult = mfSel ? hi_q : lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// tb_mdu : randomized and directed self-checking bench for mdu
// Revision 1.0
// ============================================================================
module tb_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdCtrl;
  logic [31:0] SrcA;
  logic [31:0] RD2;
  logic        mfSel;
  logic        busy;
  logic        done;
  logic        divZero;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDResult;

  int total;
  int bad;

  mdu dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mdCtrl   (mdCtrl),
    .SrcA     (SrcA),
    .RD2      (RD2),
    .mfSel    (mfSel),
    .busy     (busy),
    .done     (done),
    .divZero  (divZero),
    .HI       (HI),
    .LO       (LO),
    .MDResult (MDResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result computed with plain arithmetic, held for 33 cycles.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_rem;
  bit          m_done, m_dz;
  longint      sq, sr, sp;
  logic [63:0] up;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = 0; m_lo = 0; m_rem = 0; m_done = 0; m_dz = 0;
    end else begin
      m_done = 0;
      m_dz   = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1;
        end
      end else if (start) begin
        case (mdCtrl)
          3'd0: begin
            sp = longint'($signed(SrcA)) * longint'($signed(RD2));
            {p_hi, p_lo} = sp; m_rem = 33;
          end
          3'd1: begin
            up = {32'd0, SrcA} * {32'd0, RD2};
            {p_hi, p_lo} = up; m_rem = 33;
          end
          3'd2: begin
            if (RD2 == 0) begin m_done = 1; m_dz = 1; end
            else begin
              sq = longint'($signed(SrcA)) / longint'($signed(RD2));
              sr = longint'($signed(SrcA)) % longint'($signed(RD2));
              p_lo = sq[31:0]; p_hi = sr[31:0]; m_rem = 33;
            end
          end
          3'd3: begin
            if (RD2 == 0) begin m_done = 1; m_dz = 1; end
            else begin p_lo = SrcA / RD2; p_hi = SrcA % RD2; m_rem = 33; end
          end
          3'd4: m_hi = SrcA;
          3'd5: m_lo = SrcA;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_rem > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("divZero", 32'(divZero), 32'(m_dz));
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
    chk("MDResult", MDResult, mfSel ? m_hi : m_lo);
  end

  task automatic go(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk); #2;
    start = 1'b1; mdCtrl = c; SrcA = a; RD2 = b;
    @(posedge clk); #2;
    start = 1'b0; mdCtrl = 3'($urandom); SrcA = $urandom; RD2 = $urandom;
  endtask

  task automatic wait_done(input int inj, input int rst_at,
                           output int lat, output int bcnt, output logic dz);
    bit seen;
    lat = 0; bcnt = 0; dz = 1'b0; seen = 0;
    for (int n = 1; n <= 60; n++) begin
      if (!seen) begin
        @(negedge clk);
        if (busy === 1'b1) bcnt++;
        if (done === 1'b1) begin
          lat = n; dz = divZero; seen = 1;
        end else if (n == inj) begin
          #2; start = 1'b1; mdCtrl = 3'd3; SrcA = 32'd9; RD2 = 32'd3;
          @(posedge clk); #2; start = 1'b0;
        end else if (n == rst_at) begin
          #2; reset = 1'b1; #1;
          chk("rst_busy_now", 32'(busy), 32'd0);
          chk("rst_hi_now", HI, 32'd0);
          chk("rst_lo_now", LO, 32'd0);
          @(negedge clk); @(negedge clk); #2; reset = 1'b0;
        end
      end
    end
  endtask

  int          lat, bcnt;
  logic        dz;

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; mdCtrl = 3'd0; SrcA = 32'd0; RD2 = 32'd0; mfSel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    chk("reset_flags", {29'd0, busy, done, divZero}, 32'd0);
    #2; reset = 1'b0;

    go(3'd0, 32'hFFFF_FFFF, 32'd2);
    wait_done(0, 0, lat, bcnt, dz);
    chk("mult_latency", lat, 34);
    chk("mult_busy_cycles", bcnt, 33);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFE);

    go(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_done(0, 0, lat, bcnt, dz);
    chk("multu_hi", HI, 32'h0000_0001);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    go(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, 0, lat, bcnt, dz);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    go(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, 0, lat, bcnt, dz);
    chk("divwrap_lo", LO, 32'h8000_0000);
    chk("divwrap_hi", HI, 32'h0000_0000);
    chk("divwrap_flag", 32'(dz), 32'd0);

    go(3'd3, 32'd7, 32'd0);
    wait_done(0, 0, lat, bcnt, dz);
    chk("divz_latency", lat, 1);
    chk("divz_flag", 32'(dz), 32'd1);
    chk("divz_lo_kept", LO, 32'h8000_0000);
    chk("divz_hi_kept", HI, 32'h0000_0000);

    go(3'd1, 32'h0001_0000, 32'h0001_0000);
    wait_done(5, 0, lat, bcnt, dz);
    chk("ignore_latency", lat, 34);
    chk("ignore_hi", HI, 32'd1);
    chk("ignore_lo", LO, 32'd0);

    go(3'd1, 32'h0001_0000, 32'h0001_0000);
    wait_done(0, 10, lat, bcnt, dz);
    chk("abort_no_done", lat, 0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);

    mfSel = 1'b1;
    go(3'd4, 32'h1234_5678, 32'd0);
    @(negedge clk);
    chk("mthi_mdresult", MDResult, 32'h1234_5678);
    chk("mthi_no_done", {30'd0, busy, done}, 32'd0);
    #2; mfSel = 1'b0;
    go(3'd5, 32'hCAFE_BABE, 32'd0);
    @(negedge clk);
    chk("mtlo_mdresult", MDResult, 32'hCAFE_BABE);

    // Random traffic; the per-cycle compare against the model does the checking.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk); #2;
      start  = ($urandom_range(0, 3) == 0);
      mdCtrl = 3'($urandom);
      mfSel  = 1'($urandom);
      case ($urandom_range(0, 5))
        0: SrcA = 32'h8000_0000;
        1: SrcA = 32'hFFFF_FFFF;
        default: SrcA = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: RD2 = 32'd0;
        1: RD2 = 32'hFFFF_FFFF;
        2: RD2 = 32'($urandom_range(1, 15));
        default: RD2 = $urandom;
      endcase
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1; #2; reset = 1'b0;
      end
    end
    @(negedge clk); #2; start = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
